pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field MEM/WB pipeline register; generic payload, valid/ready handshake on both sides, synchronous flush, and a 2-entry skid buffer.
- Drop-in for any stage boundary (IF/ID through MEM/WB) where the downstream stage can stall without a combinational ready path back to the upstream stage.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 101, payload width in bits; default packs ALUResult(32) + read_data(32) + rd(5) + PCplus4(32).
- RESET_VAL, 0, value loaded into both payload registers on reset.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block can accept payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload available to downstream.
- out_ready  input  1  downstream accepts payload this cycle.
- out_data  output  DATA_W  payload to downstream.
- flush  input  1  synchronous discard of all held entries.
- stat_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- The clock is clk; the reset is reset, asynchronous and active-high.
- Storage is a main register (drives out_data) and a skid register, each with a valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States are EMPTY (none valid), BUSY (main valid), FULL (main and skid valid).
- out_valid = (state != EMPTY).
- in_ready = (state != FULL). It is a function of registered state only; no combinational path from out_ready or in_valid.
- out_data is always the main register. Its value is don't-care when out_valid=0, but it holds its last value rather than being cleared.
- Latency: 1 cycle from in_fire to out_valid, with no bubbles at full throughput (1 transfer/cycle when out_ready held high).
- EMPTY: in_fire -> main<=in_data, go to BUSY. Otherwise stay.
- BUSY, in_fire & out_fire: main<=in_data, stay in BUSY.
- BUSY, in_fire & ~out_fire: skid<=in_data, go to FULL; main unchanged.
- BUSY, ~in_fire & out_fire: go to EMPTY.
- BUSY, neither: hold.
- FULL: in_ready=0, so in_valid is ignored. out_fire -> main<=skid, go to BUSY. Otherwise hold.
- Ordering: data leaves in exactly arrival order; no duplication, no loss except by flush/reset.
- flush=1 has highest priority: next state is EMPTY regardless of in_fire/out_fire that cycle.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered; downstream already sampled it.
  - Payload registers are not cleared.
- Reset (asserted at any time, including mid-transfer): state EMPTY, main and skid payload = RESET_VAL, stall_cnt = 0.
  - Outputs immediately show out_valid=0, in_ready=1, out_data=RESET_VAL.
  - All inputs are ignored while reset is high.
- stall_cnt: +1 on each clock where out_valid & ~out_ready, saturating at 2^CNT_W-1 with no wrap.
  - stat_clr=1 forces the next value to 0, with priority over increment.
  - flush does not affect stall_cnt.

Test Plan:
- Reset release, then in_valid=1 with data 0x1, 0x2, 0x3 on consecutive cycles, out_ready=1 -> out_data 0x1, 0x2, 0x3 on the next 3 cycles, out_valid continuous, in_ready never drops, stall_cnt=0.
- Stall: out_ready=0, in_valid=1 with 0xA then 0xB -> after 2 clocks FULL, in_ready=0, out_data=0xA. Offer 0xC while FULL: ignored. Raise out_ready -> 0xA, 0xB, then 0xC (accepted once in_ready returns 1). stall_cnt equals the number of stalled cycles.
- Flush in FULL with simultaneous in_valid=1 (0xD) -> next cycle out_valid=0, in_ready=1. 0xD never appears at the output; later input 0xE emerges 1 cycle after acceptance.
- Async reset asserted mid-cycle while FULL -> out_valid=0, in_ready=1, stall_cnt=0, out_data=RESET_VAL before the next clock edge.
- CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
  - Then stat_clr=1 on a stalled cycle -> stall_cnt=0 next cycle.
  - Then +1 per subsequent stalled cycle.
- Random valid/ready (10k cycles, DATA_W=101) against a scoreboard queue -> in-order, lossless delivery, and in_ready == !FULL every cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready on both sides and a 2-entry skid buffer.
// in_ready is taken from registered state only, so no combinational ready path crosses the stage.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W    = 101,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_fire;
    logic                out_fire;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops held entries and any same-cycle input; payload keeps its last value.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);

        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
